// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared sram-like memory port arbiter.
// The inst_* and data_* groups face the pipeline requesters; the mem_* group
// faces the memory bridge. The arbiter takes the slave view; the pipeline and
// memory side together take the master view.
//
// Handshake: a requester raises *_req with its fields and holds them unchanged
// until the cycle in which *_addr_ok is high (that cycle is the acceptance).
// Each accepted request later gets exactly one *_data_ok pulse, and responses
// come back in issue order.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and load/store.
// Data has fixed priority (it belongs to the older instruction). A request
// that is presented but stalled is locked so the port sees it unchanged until
// accepted. A small FIFO of requester IDs records issue order so in-order
// responses can be steered back to the right requester.
module mem_port_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              dbg_lock_valid,
    output logic              dbg_lock_id,
    output logic [2:0]        dbg_count
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    logic          lock_valid_q, lock_valid_d;
    req_id_e       lock_id_q, lock_id_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    req_id_e       fifo_q [MAX_OUT];
    req_id_e       fifo_d [MAX_OUT];

    logic          grant_valid;
    req_id_e       grant_id;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          pop;
    req_id_e       head_id;

    // Wrap a FIFO pointer modulo MAX_OUT.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant selection, address-phase mux and acceptance.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_INST;
        if (lock_valid_q) begin
            grant_valid = 1'b1;
            grant_id    = lock_id_q;
        end else if (bus.data_req) begin
            grant_valid = 1'b1;
            grant_id    = REQ_DATA;
        end else if (bus.inst_req) begin
            grant_valid = 1'b1;
            grant_id    = REQ_INST;
        end

        fifo_empty = (count_q == '0);
        // A same-cycle pop frees the slot, so full only blocks without one.
        fifo_full  = (count_q == CW'(MAX_OUT)) && !bus.mem_data_ok;

        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_wstrb = 4'h0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (grant_valid) begin
            if (grant_id == REQ_DATA) begin
                bus.mem_req   = bus.data_req && !fifo_full;
                bus.mem_wr    = bus.data_wr;
                bus.mem_size  = bus.data_size;
                bus.mem_wstrb = bus.data_wstrb;
                bus.mem_addr  = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
            end else begin
                bus.mem_req   = bus.inst_req && !fifo_full;
                bus.mem_size  = 2'd2;
                bus.mem_addr  = bus.inst_addr;
            end
        end

        accept           = bus.mem_req && bus.mem_addr_ok;
        bus.data_addr_ok = accept && (grant_id == REQ_DATA);
        bus.inst_addr_ok = accept && (grant_id == REQ_INST);
    end

    // Response steering from the head of the issue-order FIFO.
    always_comb begin
        head_id          = fifo_q[rd_ptr_q];
        pop              = bus.mem_data_ok && !fifo_empty;
        bus.inst_data_ok = pop && (head_id == REQ_INST);
        bus.data_data_ok = pop && (head_id == REQ_DATA);
        bus.inst_rdata   = bus.mem_rdata;
        bus.data_rdata   = bus.mem_rdata;
    end

    // Next-state for the lock and the ID FIFO.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (bus.mem_req) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant_id;
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = grant_id;
            wr_ptr_d         = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= REQ_INST;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_q       <= '{default: REQ_INST};
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_q       <= fifo_d;
        end
    end

    assign dbg_lock_valid = lock_valid_q;
    assign dbg_lock_id    = lock_id_q;
    assign dbg_count      = 3'(count_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_OUT = 2.
module tb_mem_port_arbiter;
    logic       clk;
    logic       reset;
    logic       dbg_lock_valid;
    logic       dbg_lock_id;
    logic [2:0] dbg_count;
    int         total;
    int         bad;
    logic [31:0] exp_q[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_OUT(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .dbg_lock_valid (dbg_lock_valid),
        .dbg_lock_id    (dbg_lock_id),
        .dbg_count      (dbg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = 32'h0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd0;
        bus.data_wstrb  = 4'h0;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    task automatic set_inst(input logic [31:0] addr);
        bus.inst_req  = 1'b1;
        bus.inst_addr = addr;
    endtask

    task automatic set_load(input logic [31:0] addr);
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd2;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = addr;
        bus.data_wdata = 32'h0;
    endtask

    // One response cycle checked against the scoreboard (0 = inst, 1 = data).
    task automatic resp(input logic [31:0] rdata);
        logic [31:0] exp_id;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = rdata;
        settle();
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("resp_inst_ok", bus.inst_data_ok, 32'(exp_id == 32'd0));
        chk("resp_data_ok", bus.data_data_ok, 32'(exp_id == 32'd1));
        chk("resp_rdata", (exp_id == 32'd0) ? bus.inst_rdata : bus.data_rdata, rdata);
        tick();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        reset = 1'b1;
        bus.inst_addr = 32'h0000_1234;
        repeat (2) tick();
        reset = 1'b0;
        settle();
        // reset state: all outputs 0 with no requests
        chk("rst_mem_req", bus.mem_req, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_inst_addr_ok", bus.inst_addr_ok, 32'd0);
        chk("rst_data_addr_ok", bus.data_addr_ok, 32'd0);
        chk("rst_inst_data_ok", bus.inst_data_ok, 32'd0);
        chk("rst_data_data_ok", bus.data_data_ok, 32'd0);
        chk("rst_count", 32'(dbg_count), 32'd0);
        chk("rst_lock", dbg_lock_valid, 32'd0);
        chk("rst_lock_id", dbg_lock_id, 32'd0);
        idle();

        // priority: data wins, inst follows next cycle
        set_inst(32'h1c00_0000);
        set_load(32'h0000_0100);
        bus.mem_addr_ok = 1'b1;
        settle();
        chk("prio_data_ok", bus.data_addr_ok, 32'd1);
        chk("prio_inst_ok", bus.inst_addr_ok, 32'd0);
        chk("prio_mem_addr", bus.mem_addr, 32'h0000_0100);
        tick();
        exp_q.push_back(32'd1);
        bus.data_req = 1'b0;
        settle();
        chk("prio_inst_next", bus.inst_addr_ok, 32'd1);
        chk("prio_inst_addr", bus.mem_addr, 32'h1c00_0000);
        chk("prio_inst_size", 32'(bus.mem_size), 32'd2);
        chk("prio_inst_wr", bus.mem_wr, 32'd0);
        tick();
        exp_q.push_back(32'd0);
        idle();
        settle();
        chk("prio_count2", 32'(dbg_count), 32'd2);
        resp(32'h1111_1111);
        resp(32'h2222_2222);
        settle();
        chk("prio_count0", 32'(dbg_count), 32'd0);

        // lock: inst stalls 3 cycles, data arrives in cycle 2
        set_inst(32'h1c00_0040);
        settle();
        chk("lk_c1_req", bus.mem_req, 32'd1);
        chk("lk_c1_addr", bus.mem_addr, 32'h1c00_0040);
        chk("lk_c1_ok", bus.inst_addr_ok, 32'd0);
        tick();
        chk("lk_valid", dbg_lock_valid, 32'd1);
        chk("lk_id", dbg_lock_id, 32'd0);
        set_load(32'h0000_0200);
        settle();
        chk("lk_c2_addr", bus.mem_addr, 32'h1c00_0040);
        chk("lk_c2_dok", bus.data_addr_ok, 32'd0);
        tick();
        settle();
        chk("lk_c3_addr", bus.mem_addr, 32'h1c00_0040);
        tick();
        bus.mem_addr_ok = 1'b1;
        settle();
        chk("lk_c4_addr", bus.mem_addr, 32'h1c00_0040);
        chk("lk_c4_iok", bus.inst_addr_ok, 32'd1);
        chk("lk_c4_dok", bus.data_addr_ok, 32'd0);
        tick();
        exp_q.push_back(32'd0);
        bus.inst_req = 1'b0;
        settle();
        chk("lk_c5_dok", bus.data_addr_ok, 32'd1);
        chk("lk_c5_addr", bus.mem_addr, 32'h0000_0200);
        tick();
        exp_q.push_back(32'd1);
        idle();
        resp(32'h3333_3333);
        resp(32'h4444_4444);

        // full FIFO blocks a third request
        set_inst(32'h1c00_0000);
        bus.mem_addr_ok = 1'b1;
        tick();
        exp_q.push_back(32'd0);
        bus.inst_req = 1'b0;
        set_load(32'h0000_0100);
        tick();
        exp_q.push_back(32'd1);
        set_load(32'h0000_0300);
        settle();
        chk("full_mem_req", bus.mem_req, 32'd0);
        chk("full_dok", bus.data_addr_ok, 32'd0);
        tick();
        chk("full_no_lock", dbg_lock_valid, 32'd0);
        idle();
        resp(32'h0000_AAAA);
        resp(32'h0000_BBBB);

        // full + pop + push in one cycle; new id lands at wrapped wr pointer
        set_inst(32'h1c00_0100);
        bus.mem_addr_ok = 1'b1;
        tick();
        exp_q.push_back(32'd0);
        bus.inst_req = 1'b0;
        set_load(32'h0000_0500);
        tick();
        exp_q.push_back(32'd1);
        bus.data_req    = 1'b0;
        set_inst(32'h1c00_0200);
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h0000_5555;
        settle();
        chk("pp_mem_req", bus.mem_req, 32'd1);
        chk("pp_iaok", bus.inst_addr_ok, 32'd1);
        chk("pp_idok", bus.inst_data_ok, 32'd1);
        chk("pp_ddok", bus.data_data_ok, 32'd0);
        void'(exp_q.pop_front());
        tick();
        exp_q.push_back(32'd0);
        idle();
        settle();
        chk("pp_count", 32'(dbg_count), 32'd2);
        resp(32'h0000_6666);
        resp(32'h0000_7777);

        // store pass-through
        bus.data_req    = 1'b1;
        bus.data_wr     = 1'b1;
        bus.data_size   = 2'd1;
        bus.data_wstrb  = 4'b0011;
        bus.data_addr   = 32'h0000_0400;
        bus.data_wdata  = 32'hDEAD_BEEF;
        bus.mem_addr_ok = 1'b1;
        settle();
        chk("st_wr", bus.mem_wr, 32'd1);
        chk("st_wstrb", 32'(bus.mem_wstrb), 32'h3);
        chk("st_size", 32'(bus.mem_size), 32'd1);
        chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("st_dok", bus.data_addr_ok, 32'd1);
        tick();
        exp_q.push_back(32'd1);
        idle();
        resp(32'h0);

        // spurious response while empty
        bus.mem_data_ok = 1'b1;
        settle();
        chk("sp_idok", bus.inst_data_ok, 32'd0);
        chk("sp_ddok", bus.data_data_ok, 32'd0);
        tick();
        bus.mem_data_ok = 1'b0;
        settle();
        chk("sp_count", 32'(dbg_count), 32'd0);

        // reset with two outstanding
        set_inst(32'h1c00_0300);
        bus.mem_addr_ok = 1'b1;
        tick();
        tick();
        idle();
        settle();
        chk("rr_count2", 32'(dbg_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rr_count0", 32'(dbg_count), 32'd0);
        chk("rr_lock0", dbg_lock_valid, 32'd0);

        // reset with a lock held
        set_load(32'h0000_0600);
        tick();
        chk("rl_lock1", dbg_lock_valid, 32'd1);
        chk("rl_lock_id", dbg_lock_id, 32'd1);
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rl_lock0", dbg_lock_valid, 32'd0);
        chk("rl_mem_req", bus.mem_req, 32'd0);

        // stale response after reset is ignored
        bus.mem_data_ok = 1'b1;
        settle();
        chk("stale_idok", bus.inst_data_ok, 32'd0);
        chk("stale_ddok", bus.data_data_ok, 32'd0);
        tick();
        idle();
        settle();
        chk("stale_count", 32'(dbg_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single sram-like memory port between the instruction-fetch requester and the data (load/store) requester. Sits between the IF/EXE-MEM pipeline stages and the memory bridge. Arbitrates address-phase requests, holds a grant stable until it is accepted, and records the issue order of accepted requests. Routes each returned `data_ok`/`rdata` back to the requester that issued the matching request.

## Interface
Parameters:
- MAX_OUT, 2, maximum accepted-but-unanswered requests; legal values 1..4; ID FIFO depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok.
- inst_addr  in  32  fetch address (read only, size fixed 2'd2, wstrb 4'h0).
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  32  fetch data.
- data_req  in  1  load/store request; held stable until data_addr_ok.
- data_wr  in  1  1 = store.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte enables for stores.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid / store complete this cycle.
- data_rdata  out  32  load data.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared-port request.
- mem_addr_ok  in  1  shared port accepted request.
- mem_data_ok  in  1  shared port returns response (in issue order).
- mem_rdata  in  32  response data.

## Operation
- Grant selection:
  - If the lock is valid, grant = lock_id.
  - Otherwise grant = DATA if data_req, else INST if inst_req, else none.
  - DATA has fixed priority because it belongs to the older instruction.
- mem_req = (granted requester's req) && !fifo_full.
- mem_* fields are muxed from the granted requester. For INST: mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
- Accept = mem_req && mem_addr_ok.
  - The granted requester's addr_ok = Accept. The other requester's addr_ok = 0.
- Lock:
  - Set lock_valid = 1 and lock_id = grant when mem_req && !mem_addr_ok. This keeps the presented request unchanged until accepted.
  - Clear the lock on Accept.
  - While fifo_full, no lock is taken, because mem_req is low.
- ID FIFO:
  - Depth MAX_OUT; entry = 1-bit requester ID.
  - Push the grant ID on Accept. Pop the head on mem_data_ok when not empty.
  - Read and write pointers wrap modulo MAX_OUT. A count register tracks occupancy, range 0..MAX_OUT.
  - Simultaneous push and pop: count unchanged, both pointers advance. Legal when full, since the pop frees the slot in the same cycle.
- Response routing (combinational):
  - inst_data_ok = mem_data_ok && !empty && head == INST.
  - data_data_ok = mem_data_ok && !empty && head == DATA.
  - inst_rdata = data_rdata = mem_rdata.
- mem_data_ok while the FIFO is empty is a protocol error: it is ignored, no data_ok is raised, and count stays 0.
- fifo_full = (count == MAX_OUT) && !mem_data_ok. This lets a same-cycle pop free a slot for a same-cycle push.

## Timing
- Reset values:
  - lock_valid = 0, lock_id = INST, count = 0, pointers = 0.
  - All outputs are combinational from state and inputs. With all req inputs low after reset, every output is 0 except the rdata pass-throughs.
- Address phase: zero added latency; req → mem_req in the same cycle.
- Response phase: zero added latency; mem_data_ok → *_data_ok in the same cycle.
- Back-to-back issue: one Accept per cycle, sustained while count < MAX_OUT or a pop occurs the same cycle.
- Lock persists across any number of stall cycles. A data_req arriving while an INST request is locked waits until the INST Accept, then wins the next cycle.
- Reset mid-operation:
  - Reset clears the lock and the FIFO in one cycle.
  - Responses arriving after reset for pre-reset requests are treated as empty-FIFO errors. The memory side must be reset in the same cycle.

## Test plan
- Both data_req and inst_req asserted, mem_addr_ok = 1 → data_addr_ok = 1, inst_addr_ok = 0 in that cycle. inst_addr_ok = 1 the next cycle (data_req dropped).
- inst_req alone with mem_addr_ok = 0 for 3 cycles, data_req asserted in cycle 2, mem_addr_ok = 1 in cycle 4 → mem_addr stays the inst address in cycles 1–4. Data is granted in cycle 5.
- MAX_OUT = 2: issue INST@0x1c000000, DATA load@0x100, then a third request with no response → mem_req = 0 on the third. Responses 0xAAAA, then 0xBBBB → inst_data_ok with 0xAAAA, then data_data_ok with 0xBBBB.
- FIFO full plus mem_data_ok and a new Accept in the same cycle → count stays 2, the head advances, and the new ID is stored at the wrapped write pointer.
- Store (wr = 1, wstrb = 4'b0011, size = 1) → mem_wr, mem_wstrb and mem_size pass through, and data_data_ok pulses on the response.
- Spurious mem_data_ok with the FIFO empty → no data_ok output. Reset asserted with 2 outstanding → count = 0 and lock_valid = 0 the next cycle.
